// File: rtl/ikaopll_pkg.sv
// Shared sizing helpers and default slot-count widths for the OPLL slot sequencer.
package ikaopll_pkg;

  // Never returns 0, so a result can always size a vector.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  localparam int unsigned NumChDefault = 9;
  localparam int unsigned SlotsDefault = 2 * NumChDefault;
  localparam int unsigned CW           = clog2(SlotsDefault);
  localparam int unsigned CHW          = clog2(NumChDefault);

  typedef logic [CW-1:0] cycle_idx_t;

endpackage

// File: rtl/ikaopll_rst_stretch.sv
// Synchronous reset stretcher: holds the internal reset low for a number of phiM enables.
module ikaopll_rst_stretch import ikaopll_pkg::*; #(
  parameter int unsigned Target = 72
) (
  input  logic clk_i,
  input  logic ic_ni,
  input  logic phim_en_i,
  output logic mrst_no
);

  localparam int unsigned CntW = clog2(Target + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mrst_q, mrst_d;

  always_comb begin
    cnt_d  = cnt_q;
    mrst_d = mrst_q;
    if (!mrst_q && phim_en_i) begin
      if (cnt_q == CntW'(Target - 1)) mrst_d = 1'b1;
      else                            cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!ic_ni) begin
      cnt_q  <= '0;
      mrst_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mrst_q <= mrst_d;
    end
  end

  assign mrst_no = mrst_q;

endmodule

// File: rtl/ikaopll_slot_sequencer.sv
// Slot/timing sequencer: phiM -> phi1 enables, operator slot counter, per-slot output windows.
module ikaopll_slot_sequencer import ikaopll_pkg::*; #(
  parameter int unsigned PRESCALE    = 4,
  parameter int unsigned NUM_CH      = 9,
  parameter int unsigned RHY_CH      = 3,
  parameter bit          FAST_RESET  = 1'b0,
  parameter int unsigned RST_STRETCH = 72,
  parameter int unsigned CYC_W       = clog2(2 * NUM_CH),
  parameter int unsigned CH_W        = clog2(NUM_CH)
) (
  input  logic             i_EMUCLK,
  input  logic             i_IC_n,
  input  logic             i_phiM_PCEN_n,
  input  logic             i_RHYTHM_EN,
  output logic             o_phi1_PCEN_n,
  output logic             o_phi1_NCEN_n,
  output logic             o_DAC_EN,
  output logic             o_MRST_n,
  output logic [CYC_W-1:0] o_CYCLE,
  output logic [CH_W-1:0]  o_CH,
  output logic             o_MnC_SEL,
  output logic             o_CYCLE_00,
  output logic             o_RHYTHM_ACT,
  output logic             o_MO_CTRL,
  output logic             o_RO_CTRL,
  output logic             o_MO_SAMPLE,
  output logic             o_RO_SAMPLE
);

  localparam int unsigned Slots    = 2 * NUM_CH;
  localparam int unsigned PW       = clog2(PRESCALE);
  localparam int unsigned RhyFirst = NUM_CH - RHY_CH;

  logic             phim_en, mrst_n, en, ncen, pcen;
  logic [PW-1:0]    pre_q, pre_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CH_W-1:0]  nxt_ch;
  logic             rhy_q, rhy_d, mo_q, mo_d, ro_q, ro_d, rhy_slot;

  assign phim_en = ~i_phiM_PCEN_n;

  ikaopll_rst_stretch #(
    .Target (FAST_RESET ? 2 : RST_STRETCH)
  ) u_rst_stretch (
    .clk_i     (i_EMUCLK),
    .ic_ni     (i_IC_n),
    .phim_en_i (phim_en),
    .mrst_no   (mrst_n)
  );

  // Everything is frozen until the stretched reset releases.
  assign en   = phim_en & mrst_n;
  assign ncen = en & (pre_q == '0);
  assign pcen = en & (pre_q == PW'(PRESCALE / 2));

  always_comb begin
    pre_d    = pre_q;
    cyc_d    = cyc_q;
    rhy_d    = rhy_q;
    mo_d     = mo_q;
    ro_d     = ro_q;
    nxt_ch   = '0;
    rhy_slot = 1'b0;
    if (en) pre_d = (pre_q == PW'(PRESCALE - 1)) ? '0 : pre_q + 1'b1;
    if (ncen) begin
      if (cyc_q == CYC_W'(Slots - 1)) begin
        cyc_d = '0;
        rhy_d = i_RHYTHM_EN;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
      // Decode the slot being entered with the rhythm mode of the frame it belongs to.
      nxt_ch   = CH_W'(cyc_d >> 1);
      rhy_slot = rhy_d & (32'(nxt_ch) >= RhyFirst);
      mo_d     = cyc_d[0] & ~rhy_slot;
      ro_d     = cyc_d[0] & rhy_slot;
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (!i_IC_n) begin
      pre_q <= '0;
      cyc_q <= '0;
      rhy_q <= 1'b0;
      mo_q  <= 1'b0;
      ro_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cyc_q <= cyc_d;
      rhy_q <= rhy_d;
      mo_q  <= mo_d;
      ro_q  <= ro_d;
    end
  end

  assign o_phi1_NCEN_n = ~ncen;
  assign o_phi1_PCEN_n = ~pcen;
  assign o_DAC_EN      = ncen;
  assign o_MRST_n      = mrst_n;
  assign o_CYCLE       = cyc_q;
  assign o_CH          = CH_W'(cyc_q >> 1);
  assign o_MnC_SEL     = cyc_q[0];
  assign o_CYCLE_00    = (cyc_q == '0);
  assign o_RHYTHM_ACT  = rhy_q;
  assign o_MO_CTRL     = mo_q;
  assign o_RO_CTRL     = ro_q;
  assign o_MO_SAMPLE   = ncen & mo_q;
  assign o_RO_SAMPLE   = ncen & ro_q;

endmodule

// File: tb/tb_ikaopll_slot_sequencer.sv
// Randomised bench: default sequencer and a small fast-reset variant against an arithmetic model.
module tb_ikaopll_slot_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ic_n [2];
  logic pm_n [2];
  logic rhy_en [2];
  logic pcen_n [2];
  logic ncen_n [2];
  logic dac [2];
  logic mrst_n [2];
  logic mnc [2];
  logic c00 [2];
  logic ract [2];
  logic moc [2];
  logic roc [2];
  logic mos [2];
  logic ros [2];
  logic [4:0] a_cyc;
  logic [3:0] a_ch;
  logic [3:0] b_cyc;
  logic [2:0] b_ch;

  ikaopll_slot_sequencer u_a (
    .i_EMUCLK      (clk),
    .i_IC_n        (ic_n[0]),
    .i_phiM_PCEN_n (pm_n[0]),
    .i_RHYTHM_EN   (rhy_en[0]),
    .o_phi1_PCEN_n (pcen_n[0]),
    .o_phi1_NCEN_n (ncen_n[0]),
    .o_DAC_EN      (dac[0]),
    .o_MRST_n      (mrst_n[0]),
    .o_CYCLE       (a_cyc),
    .o_CH          (a_ch),
    .o_MnC_SEL     (mnc[0]),
    .o_CYCLE_00    (c00[0]),
    .o_RHYTHM_ACT  (ract[0]),
    .o_MO_CTRL     (moc[0]),
    .o_RO_CTRL     (roc[0]),
    .o_MO_SAMPLE   (mos[0]),
    .o_RO_SAMPLE   (ros[0])
  );

  ikaopll_slot_sequencer #(
    .PRESCALE   (6),
    .NUM_CH     (6),
    .RHY_CH     (2),
    .FAST_RESET (1'b1)
  ) u_b (
    .i_EMUCLK      (clk),
    .i_IC_n        (ic_n[1]),
    .i_phiM_PCEN_n (pm_n[1]),
    .i_RHYTHM_EN   (rhy_en[1]),
    .o_phi1_PCEN_n (pcen_n[1]),
    .o_phi1_NCEN_n (ncen_n[1]),
    .o_DAC_EN      (dac[1]),
    .o_MRST_n      (mrst_n[1]),
    .o_CYCLE       (b_cyc),
    .o_CH          (b_ch),
    .o_MnC_SEL     (mnc[1]),
    .o_CYCLE_00    (c00[1]),
    .o_RHYTHM_ACT  (ract[1]),
    .o_MO_CTRL     (moc[1]),
    .o_RO_CTRL     (roc[1]),
    .o_MO_SAMPLE   (mos[1]),
    .o_RO_SAMPLE   (ros[1])
  );

  // Model parameters per unit: prescale, slots, channels, rhythm channels, stretch length.
  int unsigned mp [2] = '{4, 6};
  int unsigned ms [2] = '{18, 12};
  int unsigned mc [2] = '{9, 6};
  int unsigned mr [2] = '{3, 2};
  int unsigned mt [2] = '{72, 2};

  // Model state: enables counted during stretch, enables since release, latched rhythm.
  int unsigned cnt [2];
  int unsigned k [2];
  bit          rhy [2];

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned slot_of(input int i);
    // A slot change happens on enables 0, P, 2P, ... so count those already consumed.
    return ((k[i] + mp[i] - 1) / mp[i]) % ms[i];
  endfunction

  task automatic check_unit(input int i);
    bit          m, e, ro, mo, car;
    int unsigned pre, slot, ch;
    string       u;
    u    = $sformatf("u%0d.", i);
    m    = cnt[i] >= mt[i];
    e    = m && !pm_n[i];
    pre  = k[i] % mp[i];
    slot = slot_of(i);
    ch   = slot / 2;
    car  = slot % 2;
    ro   = car && rhy[i] && (ch >= mc[i] - mr[i]);
    mo   = car && !ro;
    check({u, "mrst_n"}, 32'(mrst_n[i]), 32'(m));
    check({u, "ncen_n"}, 32'(ncen_n[i]), 32'(!(e && pre == 0)));
    check({u, "pcen_n"}, 32'(pcen_n[i]), 32'(!(e && pre == mp[i] / 2)));
    check({u, "dac_en"}, 32'(dac[i]), 32'(e && pre == 0));
    check({u, "cycle"}, (i == 0) ? 32'(a_cyc) : 32'(b_cyc), slot);
    check({u, "ch"}, (i == 0) ? 32'(a_ch) : 32'(b_ch), ch);
    check({u, "mnc_sel"}, 32'(mnc[i]), 32'(car));
    check({u, "cycle_00"}, 32'(c00[i]), 32'(slot == 0));
    check({u, "rhythm_act"}, 32'(ract[i]), 32'(rhy[i]));
    check({u, "mo_ctrl"}, 32'(moc[i]), 32'(mo));
    check({u, "ro_ctrl"}, 32'(roc[i]), 32'(ro));
    check({u, "mo_sample"}, 32'(mos[i]), 32'(e && pre == 0 && mo));
    check({u, "ro_sample"}, 32'(ros[i]), 32'(e && pre == 0 && ro));
  endtask

  task automatic update_model(input int i);
    if (!ic_n[i]) begin
      cnt[i] = 0;
      k[i]   = 0;
      rhy[i] = 1'b0;
    end else if (cnt[i] < mt[i]) begin
      if (!pm_n[i]) cnt[i]++;
    end else if (!pm_n[i]) begin
      if (k[i] % mp[i] == 0 && slot_of(i) == ms[i] - 1) rhy[i] = rhy_en[i];
      k[i]++;
    end
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step();
    #1;
    if (checking) begin
      check_unit(0);
      check_unit(1);
    end
    @(posedge clk);
    update_model(0);
    update_model(1);
    @(negedge clk);
  endtask

  task automatic drive_all(input logic ic, input logic pm, input logic re);
    for (int i = 0; i < 2; i++) begin
      ic_n[i]   = ic;
      pm_n[i]   = pm;
      rhy_en[i] = re;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0;
      k[i]   = 0;
      rhy[i] = 1'b0;
    end
    drive_all(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    step();
    checking = 1'b1;
    for (int n = 0; n < 9; n++) step();

    // Release and free-run without rhythm; long enough to cover the 72-enable stretch.
    drive_all(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 220; n++) step();

    // Rhythm requested mid-frame; takes effect only from the following frame.
    drive_all(1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 300; n++) step();

    // Reset unit A in the middle of a frame.
    for (int n = 0; n < 100 && slot_of(0) != 11; n++) step();
    ic_n[0] = 1'b0;
    step();
    ic_n[0] = 1'b1;
    for (int n = 0; n < 200; n++) step();

    // phiM enable every other clock: everything runs at half rate.
    for (int n = 0; n < 400; n++) begin
      pm_n[0] = n[0];
      pm_n[1] = n[0];
      step();
    end

    // Fully random enables, rhythm requests and occasional resets.
    for (int n = 0; n < 1600; n++) begin
      for (int i = 0; i < 2; i++) begin
        pm_n[i] = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 59) == 0) rhy_en[i] = ~rhy_en[i];
        ic_n[i] = ($urandom_range(0, 499) != 0);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
